bcd_display_scheduler: RTL

Sequencer that shares one combinational `binary_toBCD` converter between two 5-bit binary sources, A and B. It drives one operand into the converter at a time, captures the resulting `Decenas`/`Unidades`, and holds all four digits in display registers. It also time-multiplexes those four BCD digits onto a common-anode 4-digit 7-segment display, so a single converter instance and a single BCD-to-segment decoder serve the whole display.

---
 rtl/bcd_display_scheduler_pkg.sv | 33 +++
 rtl/bcd_display_scheduler_refresh_scanner.sv | 32 +++
 rtl/bcd_display_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/bcd_display_scheduler_pkg.sv
// rtl/bcd_display_scheduler_pkg.sv - shared encodings and widths for the BCD display scheduler
package bcd_display_scheduler_pkg;

   localparam int OP_W  = 5;
   localparam int BCD_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CONV_A = 3'd1,
      ST_CAP_A  = 3'd2,
      ST_CONV_B = 3'd3,
      ST_CAP_B  = 3'd4
   } state_t;

   localparam logic [3:0] ANODE_0 = 4'b1110;
   localparam logic [3:0] ANODE_1 = 4'b1101;
   localparam logic [3:0] ANODE_2 = 4'b1011;
   localparam logic [3:0] ANODE_3 = 4'b0111;

   function automatic logic [3:0] anode_pattern(input logic [1:0] idx);
      case (idx)
         2'd0:    return ANODE_0;
         2'd1:    return ANODE_1;
         2'd2:    return ANODE_2;
         default: return ANODE_3;
      endcase
   endfunction

   function automatic logic digit_invalid(input logic [BCD_W-1:0] d);
      return d > 4'd9;
   endfunction

endpackage

// File: rtl/bcd_display_scheduler_refresh_scanner.sv
// rtl/bcd_display_scheduler_refresh_scanner.sv - free-running prescaler and digit index for display multiplexing
module refresh_scanner
   import bcd_display_scheduler_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset,
   output logic [1:0] index,
   output logic [3:0] anodos
);

   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

   logic [PRE_W-1:0] pre;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre   <= '0;
         index <= 2'd0;
      end else if (pre == PRE_LAST) begin
         pre   <= '0;
         index <= index + 2'd1;
      end else begin
         pre   <= pre + PRE_W'(1);
      end
   end

   assign anodos = anode_pattern(index);

endmodule

// File: rtl/bcd_display_scheduler.sv
// rtl/bcd_display_scheduler.sv - shares one binary-to-BCD converter between two operands and scans four digits
module bcd_display_scheduler
   import bcd_display_scheduler_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [OP_W-1:0]  NbA,
   input  logic [OP_W-1:0]  NbB,
   input  logic             load,
   output logic [OP_W-1:0]  Nb_conv,
   input  logic [BCD_W-1:0] Decenas_in,
   input  logic [BCD_W-1:0] Unidades_in,
   output logic             busy,
   output logic             listo,
   output logic             err,
   output logic [3:0]       anodos,
   output logic [BCD_W-1:0] digito
);

   state_t state, state_next;

   logic [OP_W-1:0]  reg_a, reg_b;
   logic [BCD_W-1:0] stage_a_t, stage_a_u;
   logic [BCD_W-1:0] disp_a_t, disp_a_u, disp_b_t, disp_b_u;
   logic [1:0]       index;
   logic             accept;
   logic             capture_bad;

   assign accept      = (state == ST_IDLE) && load;
   assign capture_bad = digit_invalid(Decenas_in) || digit_invalid(Unidades_in);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (load) state_next = ST_CONV_A;
         ST_CONV_A: state_next = ST_CAP_A;
         ST_CAP_A:  state_next = ST_CONV_B;
         ST_CONV_B: state_next = ST_CAP_B;
         ST_CAP_B:  state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // B digits go straight into the display registers, which double as B staging,
   // so all four digits change on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_a     <= '0;
         reg_b     <= '0;
         stage_a_t <= '0;
         stage_a_u <= '0;
         disp_a_t  <= '0;
         disp_a_u  <= '0;
         disp_b_t  <= '0;
         disp_b_u  <= '0;
         listo     <= 1'b0;
         err       <= 1'b0;
      end else begin
         listo <= 1'b0;
         if (accept) begin
            reg_a <= NbA;
            reg_b <= NbB;
            err   <= 1'b0;
         end
         if (state == ST_CAP_A) begin
            stage_a_t <= Decenas_in;
            stage_a_u <= Unidades_in;
            if (capture_bad) err <= 1'b1;
         end
         if (state == ST_CAP_B) begin
            disp_a_t <= stage_a_t;
            disp_a_u <= stage_a_u;
            disp_b_t <= Decenas_in;
            disp_b_u <= Unidades_in;
            listo    <= 1'b1;
            if (capture_bad) err <= 1'b1;
         end
      end
   end

   always_comb begin
      Nb_conv = '0;
      case (state)
         ST_CONV_A, ST_CAP_A: Nb_conv = reg_a;
         ST_CONV_B, ST_CAP_B: Nb_conv = reg_b;
         default:             Nb_conv = '0;
      endcase
   end

   assign busy = (state != ST_IDLE);

   refresh_scanner #(
      .REFRESH_DIV(REFRESH_DIV)
   ) u_scanner (
      .clk    (clk),
      .reset  (reset),
      .index  (index),
      .anodos (anodos)
   );

   always_comb begin
      digito = '0;
      case (index)
         2'd0:    digito = disp_a_u;
         2'd1:    digito = disp_a_t;
         2'd2:    digito = disp_b_u;
         default: digito = disp_b_t;
      endcase
   end

endmodule
